// File: rtl/cpu_checker_sched_pkg.sv
// Shared encodings for the checker record scheduler: FSM states, record delimiters and verdict codes.
package cpu_checker_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_FLUSH,
        S_REPLAY,
        S_SAMPLE,
        S_REPORT
    } state_e;

    localparam logic [7:0] CH_START = 8'h5E;  // '^'
    localparam logic [7:0] CH_END   = 8'h23;  // '#'
    localparam logic [7:0] CH_NUL   = 8'h00;

    localparam logic [1:0] FMT_INVALID = 2'b00;
    localparam logic [1:0] FMT_REGWR   = 2'b01;
    localparam logic [1:0] FMT_MEMWR   = 2'b10;

endpackage

// File: rtl/cpu_checker_sched_rec_buf.sv
// Record buffer: one synchronous write port, one combinational read port.
module rec_buf #(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);
    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/cpu_checker_sched.sv
// Shares one cpu_checker among N_SRC character sources: buffer a whole record from a
// round-robin winner, reset the checker, replay the record gap-free, report the verdict.
module cpu_checker_sched
    import cpu_checker_sched_pkg::*;
#(
    parameter int N_SRC   = 4,
    parameter int SRC_W   = 2,
    parameter int MAX_REC = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_SRC-1:0]   src_valid,
    input  logic [8*N_SRC-1:0] src_char,
    output logic [N_SRC-1:0]   src_ready,
    output logic [7:0]         chk_char,
    output logic               chk_reset,
    input  logic [1:0]         chk_format,
    output logic               res_valid,
    output logic [SRC_W-1:0]   res_src,
    output logic [1:0]         res_type,
    output logic               res_ovf
);
    localparam int AW = $clog2(MAX_REC);
    localparam logic [AW:0] LEN_FULL = (AW+1)'(MAX_REC);

    state_e           state_q, state_d;
    logic [SRC_W-1:0] grant_q, grant_d, rr_ptr_q, rr_ptr_d;
    logic [AW:0]      len_q, len_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [SRC_W-1:0] res_src_q, res_src_d;
    logic [1:0]       res_type_q, res_type_d;
    logic             res_ovf_q, res_ovf_d;

    logic [7:0]       in_char;
    logic             in_xfer;
    logic             buf_we;
    logic [AW-1:0]    buf_waddr;
    logic [7:0]       buf_rdata;
    logic             pick_vld;
    logic [SRC_W-1:0] pick_idx;

    assign in_char = src_char[{grant_q, 3'b000} +: 8];
    assign in_xfer = (state_q == S_COLLECT) && src_valid[grant_q];

    // Walk downward so the source closest to rr_ptr (lowest offset) wins.
    always_comb begin
        int j;
        j        = 0;
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = N_SRC-1; k >= 0; k--) begin
            j = int'(rr_ptr_q) + k;
            if (j >= N_SRC) j = j - N_SRC;
            if (src_valid[j[SRC_W-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = j[SRC_W-1:0];
            end
        end
    end

    rec_buf #(.DEPTH(MAX_REC), .AW(AW)) u_buf (
        .clk     (clk),
        .we_i    (buf_we),
        .waddr_i (buf_waddr),
        .wdata_i (in_char),
        .raddr_i (idx_q),
        .rdata_o (buf_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            res_src_q  <= '0;
            res_type_q <= FMT_INVALID;
            res_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            res_src_q  <= res_src_d;
            res_type_q <= res_type_d;
            res_ovf_q  <= res_ovf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        len_d      = len_q;
        idx_d      = idx_q;
        res_src_d  = res_src_q;
        res_type_d = res_type_q;
        res_ovf_d  = res_ovf_q;
        buf_we     = 1'b0;
        buf_waddr  = len_q[AW-1:0];
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    grant_d = pick_idx;
                    len_d   = '0;
                    state_d = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (in_xfer) begin
                    // A full buffer loses the record to any further character, even '^'.
                    if (len_q == LEN_FULL) begin
                        res_src_d  = grant_q;
                        res_type_d = FMT_INVALID;
                        res_ovf_d  = 1'b1;
                        state_d    = S_REPORT;
                    end else if (in_char == CH_START) begin
                        buf_we    = 1'b1;
                        buf_waddr = '0;
                        len_d     = (AW+1)'(1);
                    end else if (len_q != '0) begin
                        buf_we = 1'b1;
                        len_d  = len_q + 1'b1;
                        if (in_char == CH_END) state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                idx_d   = '0;
                state_d = S_REPLAY;
            end
            S_REPLAY: begin
                idx_d = idx_q + 1'b1;
                if ({1'b0, idx_q} == len_q - 1'b1) state_d = S_SAMPLE;
            end
            S_SAMPLE: begin
                res_src_d  = grant_q;
                res_type_d = chk_format;
                res_ovf_d  = 1'b0;
                state_d    = S_REPORT;
            end
            S_REPORT: begin
                rr_ptr_d = (grant_q == SRC_W'(N_SRC-1)) ? '0 : grant_q + 1'b1;
                len_d    = '0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        src_ready = '0;
        chk_char  = CH_NUL;
        chk_reset = ~reset;
        res_valid = 1'b0;
        case (state_q)
            S_COLLECT: src_ready[grant_q] = 1'b1;
            S_FLUSH:   chk_reset = 1'b1;
            S_REPLAY:  chk_char = buf_rdata;
            S_REPORT:  res_valid = 1'b1;
            default: ;
        endcase
    end

    assign res_src  = res_src_q;
    assign res_type = res_type_q;
    assign res_ovf  = res_ovf_q;
endmodule

// File: tb/tb_cpu_checker_sched.sv
// Bench for cpu_checker_sched: string-scripted sources, a behavioural stand-in for the
// checker, and a record-level reference model computing verdict, latency and replay text.
module tb_cpu_checker_sched;
    localparam int N    = 4;
    localparam int SW   = 2;
    localparam int MAXR = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    src_valid = '0;
    logic [8*N-1:0]  src_char = '0;
    logic [N-1:0]    src_ready;
    logic [7:0]      chk_char;
    logic            chk_reset;
    logic [1:0]      chk_format = 2'b00;
    logic            res_valid;
    logic [SW-1:0]   res_src;
    logic [1:0]      res_type;
    logic            res_ovf;

    cpu_checker_sched #(.N_SRC(N), .SRC_W(SW), .MAX_REC(MAXR)) dut (
        .clk        (clk),
        .reset      (reset),
        .src_valid  (src_valid),
        .src_char   (src_char),
        .src_ready  (src_ready),
        .chk_char   (chk_char),
        .chk_reset  (chk_reset),
        .chk_format (chk_format),
        .res_valid  (res_valid),
        .res_src    (res_src),
        .res_type   (res_type),
        .res_ovf    (res_ovf)
    );

    always #5 clk = ~clk;

    string       src_str [N];
    int          src_pos [N];
    bit          gap_en [N];
    bit          xfer_pend [N];
    string       ck_buf = "";
    int          cyc = 0, hash_cyc = 0, last_xfer_cyc = 0, bad_ready = 0;
    int          n_pass = 0, n_fail = 0;

    logic [31:0] q_src [$];
    logic [31:0] q_typ [$];
    logic [31:0] q_ovf [$];
    int          q_lh [$];
    int          q_ll [$];
    string       q_rep [$];

    function automatic bit is_hex(input byte c);
        return (c >= "0" && c <= "9") || (c >= "a" && c <= "f") || (c >= "A" && c <= "F");
    endfunction

    // Stand-in checker rule: '^' ... '#', '@' + 8 hex digits + ':', then '$' => reg, '*' => mem.
    function automatic logic [1:0] classify(input string r);
        int at = -1;
        if (r.len() < 2 || r[0] != "^" || r[r.len()-1] != "#") return 2'b00;
        for (int i = 0; i < r.len(); i++) if (r[i] == "@" && at < 0) at = i;
        if (at < 0 || at + 9 >= r.len()) return 2'b00;
        for (int k = 1; k <= 8; k++) if (!is_hex(r[at+k])) return 2'b00;
        if (r[at+9] != ":") return 2'b00;
        for (int i = 0; i < r.len(); i++) if (r[i] == "$") return 2'b01;
        for (int i = 0; i < r.len(); i++) if (r[i] == "*") return 2'b10;
        return 2'b00;
    endfunction

    // What the scheduler should extract from a source's character stream.
    function automatic void model(input string s, output string rec, output int ovf);
        rec = "";
        ovf = 0;
        for (int i = 0; i < s.len(); i++) begin
            if (rec.len() == MAXR) begin
                ovf = 1;
                return;
            end
            if (s[i] == "^") rec = "^";
            else if (rec.len() > 0) begin
                rec = $sformatf("%s%c", rec, s[i]);
                if (s[i] == "#") return;
            end
        end
    endfunction

    function automatic string rand_rec(input int kind);
        case (kind)
            0: return $sformatf("^%0d@%08x: $%0d <= %08x#", $urandom_range(9, 1), $urandom,
                                $urandom_range(31, 1), $urandom);
            1: return $sformatf("^%0d@%08x: *%04x <= %08x#", $urandom_range(9, 1), $urandom,
                                $urandom_range(65535, 0), $urandom);
            default: return $sformatf("^%0d@%04x: $%0d <= %08x#", $urandom_range(9, 1),
                                      $urandom_range(65535, 0), $urandom_range(31, 1), $urandom);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        assert (obs === want) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0d want %0d", tag, obs, want);
        end
    endtask

    task automatic chk_s(input string tag, input string obs, input string want);
        assert (obs == want) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got '%s' want '%s'", tag, obs, want);
        end
    endtask

    // Source drivers: consume on the edge after a handshake, then present the next char.
    initial begin
        string t;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (xfer_pend[i]) begin
                    src_pos[i]++;
                    xfer_pend[i] = 1'b0;
                end
                t = src_str[i];
                src_valid[i] = (src_pos[i] < t.len()) && (!gap_en[i] || $urandom_range(1, 0) == 1);
                src_char[8*i +: 8] = (src_pos[i] < t.len()) ? t[src_pos[i]] : 8'h00;
            end
        end
    end

    // Handshake monitor, behavioural checker and result capture, all sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!$onehot0(src_ready)) bad_ready++;
            for (int i = 0; i < N; i++) begin
                if (src_valid[i] && src_ready[i]) begin
                    xfer_pend[i] = 1'b1;
                    last_xfer_cyc = cyc;
                    if (src_char[8*i +: 8] == 8'h23) hash_cyc = cyc;
                end
            end
            if (chk_reset) ck_buf = "";
            else if (chk_char != 8'h00) ck_buf = $sformatf("%s%c", ck_buf, chk_char);
            chk_format = classify(ck_buf);
            if (res_valid) begin
                q_src.push_back(32'(res_src));
                q_typ.push_back(32'(res_type));
                q_ovf.push_back(32'(res_ovf));
                q_lh.push_back(cyc - hash_cyc);
                q_ll.push_back(cyc - last_xfer_cyc);
                q_rep.push_back(ck_buf);
            end
        end
    end

    task automatic expect_rec(input string tag, input int src, input string sent);
        string rec;
        int    ovf;
        int    t = 0;
        model(sent, rec, ovf);
        while (q_src.size() == 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_arrived"}, 32'(q_src.size() != 0), 32'd1);
        if (q_src.size() != 0) begin
            chk({tag, "_src"}, q_src.pop_front(), 32'(src));
            chk({tag, "_ovf"}, q_ovf.pop_front(), 32'(ovf));
            chk({tag, "_type"}, q_typ.pop_front(), ovf ? 32'd0 : 32'(classify(rec)));
            if (ovf != 0) begin
                chk({tag, "_ovf_lat"}, 32'(q_ll.pop_front()), 32'd1);
                void'(q_lh.pop_front());
                void'(q_rep.pop_front());
            end else begin
                chk({tag, "_lat"}, 32'(q_lh.pop_front()), 32'(rec.len() + 3));
                chk_s({tag, "_replay"}, q_rep.pop_front(), rec);
                void'(q_ll.pop_front());
            end
        end
    endtask

    initial begin
        string s, a, b, c;
        int    t;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(src_ready), 32'd0);
        chk("rst_chk_char", 32'(chk_char), 32'd0);
        chk("rst_chk_reset", 32'(chk_reset), 32'd1);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_src", 32'(res_src), 32'd0);
        chk("rst_res_type", 32'(res_type), 32'd0);
        chk("rst_res_ovf", 32'(res_ovf), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_chk_reset", 32'(chk_reset), 32'd0);
        chk("idle_ready", 32'(src_ready), 32'd0);

        s = "^10@00003000: $ 1 <= 00000001#";
        src_str[1] = {src_str[1], s};
        expect_rec("regwr", 1, s);

        // The full-width memory record does not fit a 32-entry buffer; a shorter one follows.
        s = "^5@0000300c: *00000004 <= 0000abcd#";
        a = "^5@0000300c: *0004 <= 0000abcd#";
        src_str[0] = {src_str[0], s, a};
        expect_rec("memwr_long", 0, s);
        expect_rec("memwr", 0, a);

        s = "^5@300c: $2 <= 00000001#";
        src_str[3] = {src_str[3], s};
        expect_rec("bad_pc", 3, s);

        a = rand_rec($urandom_range(2, 0));
        b = rand_rec($urandom_range(2, 0));
        c = rand_rec($urandom_range(2, 0));
        src_str[0] = {src_str[0], a};
        src_str[2] = {src_str[2], b};
        src_str[3] = {src_str[3], c};
        expect_rec("cont0", 0, a);
        expect_rec("cont2", 2, b);
        expect_rec("cont3", 3, c);

        s = "^";
        for (int i = 0; i < 40; i++) s = $sformatf("%s%c", s, 8'($urandom_range(122, 97)));
        a = rand_rec(1);
        src_str[2] = {src_str[2], s, a};
        expect_rec("ovf", 2, s);
        expect_rec("ovf_next", 2, a);

        s = "^1@00000000: $";
        while (s.len() < MAXR - 1) s = {s, "1"};
        s = {s, "#"};
        src_str[1] = {src_str[1], s};
        expect_rec("len_max", 1, s);

        gap_en[2] = 1'b1;
        s = {"q#^zz^", rand_rec(0)};
        src_str[2] = {src_str[2], s};
        expect_rec("gaps", 2, s);
        gap_en[2] = 1'b0;

        src_str[0] = {src_str[0], rand_rec($urandom_range(2, 0))};
        t = 0;
        while (!(chk_reset && reset) && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("saw_flush", 32'(chk_reset), 32'd1);
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rst_chk_reset", 32'(chk_reset), 32'd1);
        chk("mid_rst_chk_char", 32'(chk_char), 32'd0);
        chk("mid_rst_ready", 32'(src_ready), 32'd0);
        chk("mid_rst_res_src", 32'(res_src), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        chk("mid_rst_no_report", 32'(q_src.size()), 32'd0);
        chk("mid_rst_idle_ready", 32'(src_ready), 32'd0);
        chk("mid_rst_idle_char", 32'(chk_char), 32'd0);

        // Last report before the reset was source 2; a cleared pointer must serve 2 before 3.
        a = rand_rec($urandom_range(2, 0));
        b = rand_rec($urandom_range(2, 0));
        src_str[3] = {src_str[3], a};
        src_str[2] = {src_str[2], b};
        expect_rec("post_rst2", 2, b);
        expect_rec("post_rst3", 3, a);

        chk("ready_onehot", 32'(bad_ready), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end
endmodule
